// File: rtl/fp_unpack_pipe.sv
// rtl/fp_unpack_pipe.sv - two-stage handshaked FP operand unpack and classify
module fp_unpack_pipe #(
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23,
    parameter int NORM_DENORM = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opa_i,
    input  logic [EXP_W+MAN_W:0]   opb_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   signA_o,
    output logic                   signB_o,
    output logic [EXP_W+1:0]       expA_o,
    output logic [EXP_W+1:0]       expB_o,
    output logic [MAN_W:0]         mantA_o,
    output logic [MAN_W:0]         mantB_o,
    output logic [4:0]             classA_o,
    output logic [4:0]             classB_o
);
    localparam int LZ_W = $clog2(MAN_W + 1);
    localparam int XW   = EXP_W + 2;

    // class vector layout: {qnan, snan, inf, zero, denorm}
    function automatic logic [4:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        logic e_zero, e_ones, f_zero;
        e_zero = (e == '0);
        e_ones = &e;
        f_zero = (f == '0);
        classify = {e_ones & !f_zero & f[MAN_W-1],
                    e_ones & !f_zero & !f[MAN_W-1],
                    e_ones & f_zero,
                    e_zero & f_zero,
                    e_zero & !f_zero};
    endfunction

    // leading zeros over the fraction; MAN_W for an all-zero fraction
    function automatic logic [LZ_W-1:0] count_lz(input logic [MAN_W-1:0] f);
        count_lz = LZ_W'(MAN_W);
        for (int i = 0; i < MAN_W; i++) begin
            if (f[i]) count_lz = LZ_W'(MAN_W - 1 - i);
        end
    endfunction

    logic [EXP_W+MAN_W:0] op [2];
    assign op[0] = opa_i;
    assign op[1] = opb_i;

    logic                 d1_sign [2];
    logic [EXP_W-1:0]     d1_exp  [2];
    logic [MAN_W-1:0]     d1_frac [2];
    logic [4:0]           d1_cls  [2];
    logic [LZ_W-1:0]      d1_lz   [2];

    logic                 s1_valid;
    logic                 s1_sign [2];
    logic [EXP_W-1:0]     s1_exp  [2];
    logic [MAN_W-1:0]     s1_frac [2];
    logic [4:0]           s1_cls  [2];
    logic [LZ_W-1:0]      s1_lz   [2];

    logic [XW-1:0]        d2_exp  [2];
    logic [MAN_W:0]       d2_mant [2];

    logic                 s2_valid;
    logic                 s2_sign [2];
    logic [XW-1:0]        s2_exp  [2];
    logic [MAN_W:0]       s2_mant [2];
    logic [4:0]           s2_cls  [2];

    logic s2_en;
    logic s1_adv;

    // S2 can take a new pair when empty or when its current pair leaves
    assign s2_en     = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_en;
    assign in_ready  = !s1_valid || s2_en;
    assign out_valid = s2_valid;

    // field split, classification and leading-zero count for both operands
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            d1_sign[i] = op[i][EXP_W+MAN_W];
            d1_exp[i]  = op[i][EXP_W+MAN_W-1:MAN_W];
            d1_frac[i] = op[i][MAN_W-1:0];
            d1_cls[i]  = classify(d1_exp[i], d1_frac[i]);
            d1_lz[i]   = count_lz(d1_frac[i]);
        end
    end

    // effective exponent and mantissa from the stored class and fields
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            d2_exp[i]  = {2'b00, s1_exp[i]};
            d2_mant[i] = {1'b1, s1_frac[i]};
            if (s1_cls[i][1]) begin
                d2_exp[i]  = '0;
                d2_mant[i] = '0;
            end else if (s1_cls[i][0]) begin
                if (NORM_DENORM != 0) begin
                    // shift by lz+1 puts the leading one in the hidden-bit slot
                    d2_mant[i] = ({1'b0, s1_frac[i]} << 1) << s1_lz[i];
                    d2_exp[i]  = '0 - XW'(s1_lz[i]);
                end else begin
                    d2_exp[i]  = XW'(1);
                    d2_mant[i] = {1'b0, s1_frac[i]};
                end
            end
        end
    end

    // pipeline registers; data only moves on its stage's load condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                s1_sign[i] <= 1'b0;
                s1_exp[i]  <= '0;
                s1_frac[i] <= '0;
                s1_cls[i]  <= '0;
                s1_lz[i]   <= '0;
                s2_sign[i] <= 1'b0;
                s2_exp[i]  <= '0;
                s2_mant[i] <= '0;
                s2_cls[i]  <= '0;
            end
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s2_en)    s2_valid <= s1_valid;
            for (int i = 0; i < 2; i++) begin
                if (in_ready && in_valid) begin
                    s1_sign[i] <= d1_sign[i];
                    s1_exp[i]  <= d1_exp[i];
                    s1_frac[i] <= d1_frac[i];
                    s1_cls[i]  <= d1_cls[i];
                    s1_lz[i]   <= d1_lz[i];
                end
                if (s1_adv) begin
                    s2_sign[i] <= s1_sign[i];
                    s2_exp[i]  <= d2_exp[i];
                    s2_mant[i] <= d2_mant[i];
                    s2_cls[i]  <= s1_cls[i];
                end
            end
        end
    end

    assign signA_o  = s2_sign[0];
    assign signB_o  = s2_sign[1];
    assign expA_o   = s2_exp[0];
    assign expB_o   = s2_exp[1];
    assign mantA_o  = s2_mant[0];
    assign mantB_o  = s2_mant[1];
    assign classA_o = s2_cls[0];
    assign classB_o = s2_cls[1];
endmodule

// File: tb/tb_fp_unpack_pipe.sv
// tb/tb_fp_unpack_pipe.sv - random stream bench for fp_unpack_pipe
module tb_fp_unpack_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] opa, opb;
    logic [15:0] h_opa, h_opb;
    assign h_opa = opa[15:0];
    assign h_opb = opb[15:0];

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid, a_signA, a_signB;
    logic [9:0]  a_expA, a_expB;
    logic [23:0] a_mantA, a_mantB;
    logic [4:0]  a_classA, a_classB;
    logic        n_in_ready, n_out_valid, n_signA, n_signB;
    logic [9:0]  n_expA, n_expB;
    logic [23:0] n_mantA, n_mantB;
    logic [4:0]  n_classA, n_classB;
    logic        h_in_ready, h_out_valid, h_signA, h_signB;
    logic [6:0]  h_expA, h_expB;
    logic [10:0] h_mantA, h_mantB;
    logic [4:0]  h_classA, h_classB;

    fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .NORM_DENORM(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .opa_i(opa), .opb_i(opb), .out_valid(a_out_valid), .out_ready(out_ready),
        .signA_o(a_signA), .signB_o(a_signB), .expA_o(a_expA), .expB_o(a_expB),
        .mantA_o(a_mantA), .mantB_o(a_mantB), .classA_o(a_classA), .classB_o(a_classB));

    fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .NORM_DENORM(0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
        .opa_i(opa), .opb_i(opb), .out_valid(n_out_valid), .out_ready(out_ready),
        .signA_o(n_signA), .signB_o(n_signB), .expA_o(n_expA), .expB_o(n_expB),
        .mantA_o(n_mantA), .mantB_o(n_mantB), .classA_o(n_classA), .classB_o(n_classB));

    fp_unpack_pipe #(.EXP_W(5), .MAN_W(10), .NORM_DENORM(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
        .opa_i(h_opa), .opb_i(h_opb), .out_valid(h_out_valid), .out_ready(out_ready),
        .signA_o(h_signA), .signB_o(h_signB), .expA_o(h_expA), .expB_o(h_expB),
        .mantA_o(h_mantA), .mantB_o(h_mantB), .classA_o(h_classA), .classB_o(h_classB));

    typedef struct { longint sign; longint e; longint m; longint cls; } res_t;
    typedef struct { longint a; longint b; } pair_t;

    int    n_checks = 0;
    int    n_err = 0;
    pair_t stim[$];
    pair_t pend[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // reference unpack from the field rules, on plain integers
    function automatic res_t ref_unpack(input longint op, input int ew, input int mw, input bit norm);
        res_t   r;
        longint emax, e, f;
        int     p;
        emax   = (longint'(1) << ew) - 1;
        e      = (op >> mw) & emax;
        f      = op & ((longint'(1) << mw) - 1);
        r.sign = (op >> (ew + mw)) & 1;
        if (e == 0 && f == 0) begin
            r.e = 0; r.m = 0; r.cls = 2;
        end else if (e == 0) begin
            r.cls = 1;
            if (norm) begin
                p = 0;
                for (int k = 0; k < mw; k++) if (((f >> k) & 1) != 0) p = k;
                r.e = -longint'(mw - 1 - p);
                r.m = f << (mw - p);
            end else begin
                r.e = 1; r.m = f;
            end
        end else if (e == emax) begin
            r.e = emax;
            r.m = (longint'(1) << mw) | f;
            if (f == 0) r.cls = 4;
            else if (((f >> (mw - 1)) & 1) != 0) r.cls = 16;
            else r.cls = 8;
        end else begin
            r.e = e; r.m = (longint'(1) << mw) | f; r.cls = 0;
        end
        r.e = r.e & ((longint'(1) << (ew + 2)) - 1);
        return r;
    endfunction

    task automatic check_side(input string tag, input logic s, input logic [63:0] e,
                              input logic [63:0] m, input logic [4:0] c, input res_t r);
        check({tag, ".sign"}, s, r.sign);
        check({tag, ".exp"}, e, r.e);
        check({tag, ".mant"}, m, r.m);
        check({tag, ".class"}, c, r.cls);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".out_valid"}, a_out_valid, 0);
        check({tag, ".in_ready"}, a_in_ready, 1);
        check({tag, ".outs"}, {a_signA, a_signB, a_expA, a_expB, a_classA, a_classB}, 0);
        check({tag, ".mants"}, {a_mantA, a_mantB}, 0);
    endtask

    initial begin
        int    cyc;
        int    first_in, first_out;
        bit    fire_in, fire_out, fired_last;
        logic  exp_rdy;
        longint r;
        pair_t p;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        stim.push_back('{64'h3F800000, 64'h80000000});
        stim.push_back('{64'h00000001, 64'h00400000});
        stim.push_back('{64'h7F800000, 64'h7FC00000});
        stim.push_back('{64'h7F800001, 64'h00007C00});
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 2; j++) begin
                r = longint'($urandom);
                case ($urandom_range(0, 4))
                    0: r = r & 64'h807FFFFF;
                    1: r = r | 64'h7F800000;
                    2: r = r & 64'h8000000F;
                    3: r = r & 64'hFFFF83FF;
                    default: ;
                endcase
                if (j == 0) p.a = r; else p.b = r;
            end
            stim.push_back(p);
        end

        cyc = 0; first_in = -1; first_out = -1; fired_last = 1'b1;
        while ((stim.size() > 0 || pend.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            out_ready = (cyc < 12) ? 1'b1 : 1'($urandom_range(0, 1));
            if (fired_last || !in_valid) begin
                if (stim.size() > 0 && (cyc < 12 || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    opa = stim[0].a[31:0];
                    opb = stim[0].b[31:0];
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            exp_rdy = !(pend.size() == 2 && !out_ready);
            check("in_ready", a_in_ready, exp_rdy);
            check("nd.in_ready", n_in_ready, exp_rdy);
            check("h.in_ready", h_in_ready, exp_rdy);
            if (a_out_valid) begin
                if (first_out < 0) first_out = cyc;
                check("out_valid_has_item", pend.size() > 0, 1);
                if (pend.size() > 0) begin
                    check("nd.out_valid", n_out_valid, 1);
                    check("h.out_valid", h_out_valid, 1);
                    check_side("a.A", a_signA, a_expA, a_mantA, a_classA, ref_unpack(pend[0].a & 64'hFFFFFFFF, 8, 23, 1));
                    check_side("a.B", a_signB, a_expB, a_mantB, a_classB, ref_unpack(pend[0].b & 64'hFFFFFFFF, 8, 23, 1));
                    check_side("nd.A", n_signA, n_expA, n_mantA, n_classA, ref_unpack(pend[0].a & 64'hFFFFFFFF, 8, 23, 0));
                    check_side("nd.B", n_signB, n_expB, n_mantB, n_classB, ref_unpack(pend[0].b & 64'hFFFFFFFF, 8, 23, 0));
                    check_side("h.A", h_signA, h_expA, h_mantA, h_classA, ref_unpack(pend[0].a & 64'hFFFF, 5, 10, 1));
                    check_side("h.B", h_signB, h_expB, h_mantB, h_classB, ref_unpack(pend[0].b & 64'hFFFF, 5, 10, 1));
                end
            end
            fire_out = a_out_valid && out_ready;
            fire_in  = in_valid && a_in_ready;
            if (fire_out && pend.size() > 0) void'(pend.pop_front());
            if (fire_in) begin
                if (first_in < 0) first_in = cyc;
                pend.push_back(stim.pop_front());
            end
            fired_last = fire_in;
            cyc++;
        end
        check("stream_drained", stim.size() + pend.size(), 0);
        check("latency", first_out - first_in, 2);

        // fill both stages, then reset asynchronously mid-cycle
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        opa = 32'h3F800000; opb = 32'h7FC00000;
        @(negedge clk);
        opa = 32'h00000001;
        @(negedge clk);
        #1 check("full_stall.in_ready", a_in_ready, 0);
        check("full_stall.out_valid", a_out_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check("post_reset.out_valid", a_out_valid, 0);
        end
        check("post_reset.in_ready", a_in_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_unpack_pipe.md
# fp_unpack_pipe

Parametrised, handshaked successor to the single-cycle FP operand unpack stage. Splits two IEEE-754-style operands into sign, widened exponent and hidden-bit mantissa, classifies each operand (zero, denormal, infinity, quiet/signalling NaN), and optionally pre-normalises denormals. It sits at the front of the FPU datapath, feeding the add/mul cores through a 2-stage valid/ready pipeline with full backpressure.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, fraction field width (operand width W = 1+EXP_W+MAN_W); MAN_W < 2^(EXP_W+1)-1 required
- NORM_DENORM, 1, 1 = left-normalise denormal mantissas and adjust exponent; 0 = pass denormals through
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operand pair this cycle
- opa_i  in  W  operand A
- opb_i  in  W  operand B
- out_valid  out  1  unpacked result valid
- out_ready  in  1  downstream accepts result
- signA_o, signB_o  out  1  sign bits
- expA_o, expB_o  out  EXP_W+2  effective biased exponent, two's complement signed
- mantA_o, mantB_o  out  MAN_W+1  {hidden bit, fraction}, normalised if enabled
- classA_o, classB_o  out  5  {qnan, snan, inf, zero, denorm}; all 0 = normal

## Operation
- Stage 1 (S1): capture operands, decode fields, classify, compute leading-zero count lz of fraction (0..MAN_W).
- Stage 2 (S2): apply normalising shift, produce outputs; S2 registers drive the output ports directly.
- Classification per operand (e = exp field, f = fraction):
  - e==0, f==0: zero; exp_o=0, mant_o=0.
  - e==0, f!=0: denorm. NORM_DENORM=0: exp_o=1, mant_o={0,f}. NORM_DENORM=1: mant_o={0,f}<<(lz+1) so MSB=1, exp_o=-lz (i.e. 1-(lz+1)), lz counted over the MAN_W-bit fraction.
  - 0<e<all-ones: normal; exp_o=e zero-extended, mant_o={1,f}.
  - e==all-ones, f==0: inf; exp_o=2^EXP_W-1, mant_o={1,0}.
  - e==all-ones, f!=0: NaN; qnan if f[MAN_W-1]=1 else snan; exp_o=2^EXP_W-1, mant_o={1,f}.
- Exactly one class bit set for non-normal operands; none for normal.
- Sign passes through unmodified for every class, including zero and NaN.
- Handshake: transfer on valid&&ready at each boundary. S2 loads when S2 empty or out_ready=1. S1 loads when S1 empty or S1 advances. in_ready = !s1_valid || !s2_valid || out_ready (combinational, no combinational path from in_valid).
- While out_valid=1 and out_ready=0, all outputs held stable.

## Timing
- Latency: opa/opb accepted at edge N -> result on outputs after edge N+2 (out_valid high in cycle N+2).
- Throughput: 1 pair/cycle when out_ready held 1; no bubbles.
- Backpressure: out_ready=0 with both stages full -> in_ready=0 same cycle; out_ready returning to 1 -> in_ready=1 same cycle, simultaneous accept and emit.
- Simultaneous in and out handshake with both stages full: S2 takes S1, S1 takes new input, no loss or duplication.
- Reset (rst_n=0, asynchronous): s1_valid, s2_valid, out_valid=0; all data outputs (sign, exp, mant, class)=0; in_ready=1 once reset completes (in_ready= !s1_valid so reads 1 during reset as well). Reset mid-operation discards all in-flight pairs; no output appears for them after release.
- Data registers update only on their stage's load condition; no update on stall.

## Test plan
- Reset: drive rst_n=0 mid-stream with both stages full -> out_valid=0, all outputs 0 immediately; after release no stale result emitted, in_ready=1.
- Normal/zero (FP32 defaults): opa=0x3F800000, opb=0x80000000 -> 2 cycles later signA=0 expA=127 mantA=0x800000 classA=0; signB=1 expB=0 mantB=0 classB=5'b00010.
- Denormals, NORM_DENORM=1: opa=0x00000001, opb=0x00400000 -> expA=-22 (10'h3EA) mantA=0x800000 classA=00001; expB=0 mantB=0x800000. With NORM_DENORM=0: expA=1 mantA=0x000001.
- Specials: opa=0x7F800000, opb=0x7FC00000 -> classA=00100 expA=255 mantA=0x800000; classB=10000 mantB=0xC00000; opa=0x7F800001 -> classA=01000.
- Backpressure: stream 8 pairs, out_ready random 50% -> all 8 emitted in order, outputs stable during stalls, in_ready=0 only when both stages full and out_ready=0.
- Parametrisation: EXP_W=5, MAN_W=10 (half): opa=0x0001 -> expA=-9, mantA=0x400 classA=00001; opa=0x7C00 -> classA=00100 expA=31.
